mem_req_arbiter: RTL and testbench
==================================

# mem_req_arbiter

Round-robin arbiter that shares the single 128-bit DRAM request/response port (`mem_req_*` / `mem_resp_*`) among `NCLIENT` requesters, such as I-cache refill, D-cache refill/writeback and the debug/DMA path. It keeps two-beat line writes atomic and tracks the issuing client of every outstanding read. Each two-beat read response is routed back to that client in order. It sits between the cache/memory clients and the DRAM controller interface, in the `gclk` domain.

## Interface
Parameters:
- `NCLIENT`, 3: number of requesters (2..8).
- `TAG_DEPTH`, 8: outstanding-read capacity (power of 2).

Ports:
- `gclk`  in  iu_clk_type  clock; all logic on `posedge gclk.clk`.
- `rst`  in  1  synchronous, active-high reset.
- `req_val`  in  NCLIENT  per-client request valid.
- `req_rw`  in  NCLIENT  per-client direction, 1 = write, 0 = read.
- `req_addr`  in  NCLIENT×26  per-client line address.
- `req_data`  in  NCLIENT×128  per-client write beat.
- `req_rdy`  out  NCLIENT  per-client accept.
- `resp_val`  out  NCLIENT  per-client read-beat valid.
- `resp_data`  out  128  shared read beat.
- `mem_req_val`  out  1  request valid to the controller.
- `mem_req_rdy`  in  1  controller accept.
- `mem_req_rw`  out  1  controller direction, 1 = write.
- `mem_req_addr`  out  26  controller address.
- `mem_req_data`  out  128  controller write beat.
- `mem_resp_val`  in  1  controller read-beat valid.
- `mem_resp_data`  in  128  controller read beat.
- `resp_err`  out  1  sticky flag: a response arrived with no outstanding read.

## Operation
- One line is 32 B. A write is 2 request beats. A read is 1 request beat and returns 2 response beats.
- FSM states:
  - IDLE: arbitrate round-robin from `rr_ptr` over clients with `req_val` set. Winner `g` is combinational. A read winner is eligible only if the tag FIFO is not full; an ineligible read is skipped and the next client is considered.
  - IDLE → WR2: on an accepted write beat 0. Grant locks to `g`.
  - WR2: only client `g` is granted. Accepting beat 1 returns to IDLE.
  - If `req_val[g]` drops in WR2, hold in WR2 with `mem_req_val` low; no other client is granted.
- Accept rule: a beat is accepted when `mem_req_val & mem_req_rdy`.
- `rr_ptr` update: set to `(g+1) mod NCLIENT` on read accept or on write beat-1 accept. It does not change on write beat 0.
- Tag FIFO:
  - Push the client id on read accept.
  - Head id routes responses. A beat counter `rbeat` toggles on each `mem_resp_val`; pop when `rbeat == 1`.
  - Push and pop in the same cycle leaves the count unchanged.
  - A response with the FIFO empty sets `resp_err`, drives `resp_val` all-zero and drops the data.
- Muxing:
  - `mem_req_*` fields come from client `g`.
  - `resp_data = mem_resp_data`.
  - `resp_val[i] = mem_resp_val & (head == i)`.
- Clients must accept response beats unconditionally; there is no back-pressure.

## Timing
- Request path: zero latency. `req_rdy[i] = mem_req_rdy & grant[i] & eligible`. `mem_req_val` is asserted in the same cycle as `req_val[g]`.
- Response path: zero latency, purely combinational from `mem_resp_val` and the FIFO head.
- Back-to-back operation:
  - Full throughput of 1 beat/cycle.
  - A new transaction can be granted in the cycle after a write beat-1 or read accept.
- Reset values: state IDLE, `rr_ptr` 0, FIFO empty, `rbeat` 0, `resp_err` 0.
- Output values under reset: all `req_rdy`, `resp_val` and `mem_req_val` are 0; `mem_req_rw`, `mem_req_addr` and `mem_req_data` are 0 (client 0 muxed, gated).
- Reset mid-write or with reads outstanding:
  - Reset clears everything.
  - Responses that arrive after reset set `resp_err`. The controller is expected to be reset together with this block.

## Structure
- Constants belong in the shared package `libmemif`: `MEM_ADDR_W = 26`, `MEM_DATA_W = 128`, `MEM_LINE_BEATS = 2`.
- The FSM state enum `arb_state_type {ARB_IDLE, ARB_WR2}` also goes in `libmemif`.
- One sub-module, `mem_tag_fifo`: a `TAG_DEPTH` × `$clog2(NCLIENT)` FIFO.
  - Outputs: `full`, `empty`, `head`.
  - Synchronous reset.
  - Push and pop in the same cycle.
- Arbitration, FSM, beat counter and muxing live in `mem_req_arbiter`.

## Test plan
1. Single read, client 1, addr 0x0000040, `mem_req_rdy=1`:
   - `mem_req_addr = 0x0000040`, `rw = 0` in the same cycle.
   - Two response beats 0xA…, 0xB… give `resp_val = 3'b010` on both, then the FIFO is empty.
2. All three clients request reads continuously:
   - Grant order is 0,1,2,0,1,2.
   - Responses return to 0,1,2 in order, two beats each.
3. Client 0 writes two beats while client 2 requests a read:
   - Client 2 is not granted until client 0's beat 1 is accepted, even with a 2-cycle `req_val[0]` gap in WR2.
   - Client 2 is then granted, because `rr_ptr = 1` and client 1 is idle.
4. Eight reads outstanding (FIFO full), then client 1 reads and client 2 writes:
   - Client 1 `req_rdy = 0`; client 2's write proceeds.
   - After one response pair pops, client 1's read is accepted.
5. `mem_req_rdy` low for 5 cycles during WR2: the beat is held and `rr_ptr` is unchanged. A response pop and a new read push in the same cycle leave the FIFO count unchanged.
6. `rst` asserted in WR2 with 3 reads outstanding:
   - All outputs return to 0 and the next grant goes to client 0.
   - A stray `mem_resp_val` afterwards sets `resp_err = 1` with `resp_val = 0`.

Source files
------------

// File: rtl/libmemif_pkg.sv
// Shared DRAM-interface constants and types for the memory request path.
package libmemif;

   localparam int unsigned MEM_ADDR_W     = 26;
   localparam int unsigned MEM_DATA_W     = 128;
   localparam int unsigned MEM_LINE_BEATS = 2;

   typedef struct packed {
      logic clk;
   } iu_clk_type;

   typedef enum logic {
      ARB_IDLE,
      ARB_WR2
   } arb_state_type;

endpackage

// File: rtl/mem_tag_fifo.sv
// Client-id FIFO recording the issuer of each outstanding DRAM read, oldest at head.
module mem_tag_fifo
   import libmemif::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned IDW   = 2
) (
   input  iu_clk_type     gclk,
   input  logic           rst,
   input  logic           push,
   input  logic           pop,
   input  logic [IDW-1:0] din,
   output logic           full,
   output logic           empty,
   output logic [IDW-1:0] head
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic           clk;
   logic [IDW-1:0] mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [PW:0]    count;

   assign clk = gclk.clk;

   // Storage needs no reset; only pointers and occupancy define validity.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + (PW+1)'(1);
         else if (pop && !push) count <= count - (PW+1)'(1);
      end
   end

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one DRAM request/response port among NCLIENT requesters,
// keeping two-beat writes atomic and routing read responses back in issue order.
module mem_req_arbiter
   import libmemif::*;
#(
   parameter int unsigned NCLIENT   = 3,
   parameter int unsigned TAG_DEPTH = 8
) (
   input  iu_clk_type                               gclk,
   input  logic                                     rst,
   input  logic [NCLIENT-1:0]                       req_val,
   input  logic [NCLIENT-1:0]                       req_rw,
   input  logic [NCLIENT-1:0][MEM_ADDR_W-1:0]       req_addr,
   input  logic [NCLIENT-1:0][MEM_DATA_W-1:0]       req_data,
   output logic [NCLIENT-1:0]                       req_rdy,
   output logic [NCLIENT-1:0]                       resp_val,
   output logic [MEM_DATA_W-1:0]                    resp_data,
   output logic                                     mem_req_val,
   input  logic                                     mem_req_rdy,
   output logic                                     mem_req_rw,
   output logic [MEM_ADDR_W-1:0]                    mem_req_addr,
   output logic [MEM_DATA_W-1:0]                    mem_req_data,
   input  logic                                     mem_resp_val,
   input  logic [MEM_DATA_W-1:0]                    mem_resp_data,
   output logic                                     resp_err
);

   localparam int unsigned IDW = (NCLIENT > 1) ? $clog2(NCLIENT) : 1;

   logic          clk;
   arb_state_type state, state_nxt;
   logic [IDW-1:0] lock_g, lock_nxt;
   logic [IDW-1:0] rr_ptr, rr_nxt;
   logic           rbeat, rbeat_nxt;
   logic           err_nxt;
   logic [IDW-1:0] g;
   logic [IDW-1:0] cand;
   logic           eligible;
   logic           accept;
   logic           push, pop;
   logic           full, empty;
   logic [IDW-1:0] head;

   assign clk = gclk.clk;

   function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
      return (32'(id) == NCLIENT - 1) ? '0 : id + IDW'(1);
   endfunction

   // Winner selection: locked client during WR2, otherwise first eligible from rr_ptr.
   always_comb begin
      g        = rr_ptr;
      cand     = '0;
      eligible = 1'b0;
      if (state == ARB_WR2) begin
         g        = lock_g;
         eligible = req_val[lock_g];
      end else begin
         for (int unsigned i = 0; i < NCLIENT; i++) begin
            cand = IDW'((32'(rr_ptr) + i) % NCLIENT);
            if (!eligible && req_val[cand] && (req_rw[cand] || !full)) begin
               eligible = 1'b1;
               g        = cand;
            end
         end
      end
   end

   assign mem_req_val  = eligible & ~rst;
   assign accept       = mem_req_val & mem_req_rdy;
   assign mem_req_rw   = rst ? 1'b0 : req_rw[g];
   assign mem_req_addr = rst ? '0 : req_addr[g];
   assign mem_req_data = rst ? '0 : req_data[g];

   always_comb begin
      req_rdy = '0;
      if (accept) req_rdy[g] = 1'b1;
   end

   assign push = accept & (state == ARB_IDLE) & ~req_rw[g];
   assign pop  = mem_resp_val & ~empty & rbeat;

   assign resp_data = mem_resp_data;

   always_comb begin
      resp_val = '0;
      if (mem_resp_val && !empty && !rst) resp_val[head] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ARB_IDLE;
         lock_g   <= '0;
         rr_ptr   <= '0;
         rbeat    <= 1'b0;
         resp_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         lock_g   <= lock_nxt;
         rr_ptr   <= rr_nxt;
         rbeat    <= rbeat_nxt;
         resp_err <= err_nxt;
      end
   end

   // rr_ptr moves only when a whole transaction completes, never on write beat 0.
   always_comb begin
      state_nxt = state;
      lock_nxt  = lock_g;
      rr_nxt    = rr_ptr;
      rbeat_nxt = rbeat;
      err_nxt   = resp_err;
      case (state)
         ARB_IDLE: begin
            if (accept) begin
               if (req_rw[g]) begin
                  state_nxt = ARB_WR2;
                  lock_nxt  = g;
               end else begin
                  rr_nxt = next_id(g);
               end
            end
         end
         ARB_WR2: begin
            if (accept) begin
               state_nxt = ARB_IDLE;
               rr_nxt    = next_id(g);
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
      if (mem_resp_val) begin
         if (empty) err_nxt   = 1'b1;
         else       rbeat_nxt = ~rbeat;
      end
   end

   mem_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .IDW   (IDW)
   ) u_tag_fifo (
      .gclk  (gclk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (g),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed scenarios plus randomized traffic checked against a queue-based transaction model.
module tb_mem_req_arbiter;
   import libmemif::*;

   localparam int NC = 3;
   localparam int TD = 8;

   logic clk = 1'b0;
   iu_clk_type gclk;
   logic rst;
   logic [NC-1:0] req_val, req_rw, req_rdy, resp_val;
   logic [NC-1:0][MEM_ADDR_W-1:0] req_addr;
   logic [NC-1:0][MEM_DATA_W-1:0] req_data;
   logic [MEM_DATA_W-1:0] resp_data, mem_req_data, mem_resp_data;
   logic [MEM_ADDR_W-1:0] mem_req_addr;
   logic mem_req_val, mem_req_rdy, mem_req_rw, mem_resp_val, resp_err;

   int checks = 0;
   int errors = 0;

   // Model: locked writer (-1 none), rotation start, outstanding read owners, beat parity, sticky error.
   int m_lock = -1;
   int m_rr = 0;
   int q[$];
   bit m_beat = 1'b0;
   bit m_err = 1'b0;
   int glog[$];

   always #5 clk = ~clk;
   assign gclk.clk = clk;

   mem_req_arbiter #(.NCLIENT(NC), .TAG_DEPTH(TD)) dut (
      .gclk(gclk), .rst(rst),
      .req_val(req_val), .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
      .req_rdy(req_rdy), .resp_val(resp_val), .resp_data(resp_data),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data), .resp_err(resp_err)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle_inputs();
      req_val = '0; req_rw = '0; req_addr = '0; req_data = '0;
      mem_req_rdy = 1'b1; mem_resp_val = 1'b0; mem_resp_data = '0;
   endtask

   // One clock: compare outputs to the model mid-cycle, then advance the model at the edge.
   task automatic tick();
      int g;
      bit elig;
      logic [NC-1:0] e_rv;
      #4;
      g = 0;
      elig = 1'b0;
      if (!rst) begin
         if (m_lock >= 0) begin
            g = m_lock;
            elig = req_val[g];
         end else begin
            for (int i = 0; i < NC; i++) begin
               int c;
               c = (m_rr + i) % NC;
               if (!elig && req_val[c] && (req_rw[c] || q.size() < TD)) begin
                  elig = 1'b1;
                  g = c;
               end
            end
         end
      end
      chk("mem_req_val", 128'(mem_req_val), 128'(elig));
      chk("req_rdy", 128'(req_rdy), (elig && mem_req_rdy) ? (128'(1) << g) : 128'(0));
      if (elig) begin
         chk("mem_req_rw", 128'(mem_req_rw), 128'(req_rw[g]));
         chk("mem_req_addr", 128'(mem_req_addr), 128'(req_addr[g]));
         chk("mem_req_data", 128'(mem_req_data), 128'(req_data[g]));
      end else if (rst) begin
         chk("rst_fields", 128'({mem_req_rw, mem_req_addr}) | 128'(mem_req_data), 128'(0));
      end
      e_rv = '0;
      if (!rst && mem_resp_val && q.size() > 0) e_rv[q[0]] = 1'b1;
      chk("resp_val", 128'(resp_val), 128'(e_rv));
      chk("resp_data", 128'(resp_data), 128'(mem_resp_data));
      chk("resp_err", 128'(resp_err), 128'(m_err));
      if (elig && mem_req_rdy) glog.push_back(g);
      @(posedge clk);
      if (rst) begin
         m_lock = -1; m_rr = 0; q.delete(); m_beat = 1'b0; m_err = 1'b0;
      end else begin
         if (mem_resp_val) begin
            if (q.size() > 0) begin
               if (m_beat) void'(q.pop_front());
               m_beat = !m_beat;
            end else begin
               m_err = 1'b1;
            end
         end
         if (elig && mem_req_rdy) begin
            if (m_lock >= 0) begin
               m_lock = -1;
               m_rr = (g + 1) % NC;
            end else if (req_rw[g]) begin
               m_lock = g;
            end else begin
               q.push_back(g);
               m_rr = (g + 1) % NC;
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   initial begin
      int resp_p;
      rst = 1'b1;
      idle_inputs();
      #1;
      do_reset();

      // Single read from client 1 and its two-beat response
      req_val = 3'b010; req_rw = 3'b000; req_addr[1] = 26'h40;
      #2;
      chk("t1_addr", 128'(mem_req_addr), 128'(26'h40));
      chk("t1_rw", 128'(mem_req_rw), 128'(0));
      tick();
      req_val = '0;
      mem_resp_val = 1'b1; mem_resp_data = {32{4'hA}};
      #2;
      chk("t1_beat0", 128'(resp_val), 128'(3'b010));
      tick();
      mem_resp_data = {32{4'hB}};
      #2;
      chk("t1_beat1", 128'(resp_val), 128'(3'b010));
      tick();
      mem_resp_val = 1'b0;

      // All clients reading continuously: rotation order and in-order response routing
      do_reset();
      glog.delete();
      req_val = 3'b111;
      repeat (6) tick();
      req_val = '0;
      chk("t2_ngrant", 128'(glog.size()), 128'(6));
      for (int k = 0; k < 6 && k < glog.size(); k++) chk("t2_order", 128'(glog[k]), 128'(k % 3));
      mem_resp_val = 1'b1;
      for (int k = 0; k < 12; k++) begin
         mem_resp_data = {4{$urandom}};
         #2;
         chk("t2_route", 128'(resp_val), 128'(1) << ((k / 2) % 3));
         tick();
      end
      mem_resp_val = 1'b0;

      // Full tag FIFO blocks reads but not writes; one popped pair frees a slot
      do_reset();
      req_val = 3'b001;
      repeat (8) tick();
      req_val = 3'b110; req_rw = 3'b100;
      #2;
      chk("t4_rd_blocked", 128'(req_rdy), 128'(3'b100));
      tick();
      tick();
      req_val = 3'b010; req_rw = 3'b000;
      mem_resp_val = 1'b1;
      #2;
      chk("t4_still_full0", 128'(req_rdy), 128'(0));
      tick();
      #2;
      chk("t4_still_full1", 128'(req_rdy), 128'(0));
      tick();
      mem_resp_val = 1'b0;
      #2;
      chk("t4_rd_accept", 128'(req_rdy), 128'(3'b010));
      tick();
      req_val = '0;

      // Reset in WR2 with reads outstanding, then a stray response
      do_reset();
      req_val = 3'b001;
      repeat (3) tick();
      req_val = 3'b100; req_rw = 3'b100;
      tick();
      rst = 1'b1; req_val = 3'b111; req_rw = 3'b000;
      #2;
      chk("t6_rst_val", 128'(mem_req_val), 128'(0));
      tick();
      rst = 1'b0; req_val = '0;
      mem_resp_val = 1'b1;
      #2;
      chk("t6_stray_rv", 128'(resp_val), 128'(0));
      tick();
      mem_resp_val = 1'b0;
      #2;
      chk("t6_err", 128'(resp_err), 128'(1));
      req_val = 3'b111;
      #2;
      chk("t6_grant0", 128'(req_rdy), 128'(3'b001));
      tick();

      // Randomized traffic with alternating slow/fast response phases
      do_reset();
      for (int cyc = 0; cyc < 4000; cyc++) begin
         resp_p = ((cyc / 500) % 2 == 1) ? 10 : 60;
         rst = ($urandom_range(0, 299) == 0);
         req_val = NC'($urandom);
         req_rw = NC'($urandom);
         for (int i = 0; i < NC; i++) begin
            req_addr[i] = MEM_ADDR_W'($urandom);
            req_data[i] = {$urandom, $urandom, $urandom, $urandom};
         end
         mem_req_rdy = ($urandom_range(0, 3) != 0);
         mem_resp_val = (q.size() > 0) ? ($urandom_range(0, 99) < resp_p)
                                       : ($urandom_range(0, 299) == 0);
         mem_resp_data = {$urandom, $urandom, $urandom, $urandom};
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
